fp_sqrt_iter: RTL and testbench
===============================

// Module: fp_sqrt_iter
// PURPOSE
//  Parametrised IEEE-style floating-point square root with valid/ready handshakes.
//  Computes either an exact, truncated result with a serial restoring root
//    (one root bit per cycle), or the single-cycle bit-trick estimate.
//  The bit-trick estimate is: subtract the bias word, arithmetic-shift right 1, add the bias word back.
//  Sits in the float datapath between operand FIFOs and consumers that tolerate multi-cycle latency.
// PARAMETERS
//  EXP_W   8  exponent width; BIAS = 2**(EXP_W-1)-1
//  MAN_W   23 stored fraction width (hidden 1 implied)
//  APPROX  0  1 = bit-trick estimate, latency 1; 0 = exact serial root, latency MAN_W+2
// PORTS
//  clk        in   1            rising-edge clock
//  arst       in   1            asynchronous active-high reset
//  in_data    in   1+EXP_W+MAN_W operand {sign,exp,frac}
//  in_valid   in   1            operand present
//  in_ready   out  1            block can accept; high only in IDLE
//  out_data   out  1+EXP_W+MAN_W result, held stable while out_valid && !out_ready
//  out_valid  out  1            result present
//  out_ready  in   1            consumer accepts
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0; arst aborts any operation immediately.
//  Accept on in_valid&&in_ready (cycle t); operand registered, in_ready drops at t+1.
//  FSM: IDLE -(accept)-> special ? DONE : (APPROX ? DONE : CALC).
//   CALC runs MAN_W+1 iterations, then DONE. DONE -(out_ready)-> IDLE.
//  Latency:
//   Exact, normal operand: out_valid rises at t+MAN_W+2.
//   Special operand, or APPROX=1: out_valid rises at t+1.
//  Handshake: out_valid stays high and out_data is frozen until out_ready.
//   Transfer cycle returns to IDLE; in_ready=1 next cycle (no same-cycle re-accept).
//   in_valid while busy is ignored; the producer holds.
//  Classification, applied in both modes, first match wins:
//   exp==0: zero/denormal, flushed; result = {sign,0...0}, so -0 -> -0.
//   exp==all1s && frac!=0: NaN -> canonical qNaN {0,1s,1,0..0}.
//   sign==1, nonzero: canonical qNaN.
//   +inf -> +inf. Everything else is a normal operand.
//  Exact path:
//   E = exp-BIAS (signed); odd = E[0]; S = {1,frac} (MAN_W+1 bits).
//   Radicand N = S << (MAN_W+odd), width 2*MAN_W+2.
//   Restoring integer sqrt: one bit per cycle, MSB first; remainder MAN_W+3 bits.
//   Root R has MAN_W+1 bits, R[MAN_W]=1 always.
//   Result = {0, ((E-odd)>>>1)+BIAS, R[MAN_W-1:0]}, truncation (round toward zero).
//   Exponent cannot overflow or underflow for any normal input.
//  APPROX path:
//   out = {t[MSB],t[MSB:1]} + B, where t = in - B and B = {0,BIAS,0..0}.
//   Wrap-around is modulo 2**(1+EXP_W+MAN_W).
// STRUCTURE
//  Package fp_sqrt_pkg: state enum (IDLE,CALC,DONE); functions bias(EXP_W), qnan(EXP_W,MAN_W), pinf().
//  Sub-module isqrt_serial (W=MAN_W+1): start/busy/done, N in, root out.
//   Holds the remainder, root and bit counter; one step per cycle.
//  Top level holds classification, exponent math, handshake FSM and output register.
// TESTING
//  Exact, 0x40800000 (4.0) -> 0x40000000, out_valid exactly 25 cycles after accept.
//  Exact, 0x40000000 (2.0) -> 0x3FB504F3; 0x3F800000 -> 0x3F800000; 0x3E800000 (0.25) -> 0x3F000000.
//  Specials, each at latency 1:
//   0xBF800000 -> 0x7FC00000; 0x7F800001 -> 0x7FC00000.
//   0x7F800000 -> 0x7F800000; 0x80000000 -> 0x80000000; 0x00000001 -> 0x00000000.
//  Backpressure: out_ready low 5 cycles after out_valid -> out_data stable, in_ready=0.
//   Then pulse out_ready -> IDLE next cycle; 2nd operand is accepted only then.
//  Reset mid-CALC (iteration 10): out_valid=0, in_ready=1 immediately; next op 0x41100000 (9.0) -> 0x40400000.
//  APPROX=1: 0x40800000 -> 0x40000000 at latency 1.
//   Random 10k normals compared against the bit-trick model; exact mode compared against a truncated-sqrt model.

Source files
------------

// File: rtl/fp_sqrt_pkg.sv
// Shared types and constant helpers for the floating-point square-root block.
// Helpers return a wide word; callers cast down to their own format width.
package fp_sqrt_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_NORM = 2'd0,
      CLS_ZERO = 2'd1,
      CLS_NAN  = 2'd2,
      CLS_INF  = 2'd3
   } op_class_t;

   function automatic logic [MAX_W-1:0] bias(input int unsigned exp_w);
      return (MAX_W'(1) << (exp_w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] pinf(input int unsigned exp_w, input int unsigned man_w);
      return ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
   endfunction

   // Canonical quiet NaN: positive, all-ones exponent, fraction MSB set.
   function automatic logic [MAX_W-1:0] qnan(input int unsigned exp_w, input int unsigned man_w);
      return pinf(exp_w, man_w) | (MAX_W'(1) << (man_w - 1));
   endfunction

endpackage

// File: rtl/isqrt_serial.sv
// Serial restoring integer square root: one root bit per cycle, MSB first.
// The first step is taken on the start edge, so the root is complete W cycles later.
module isqrt_serial #(
   parameter int unsigned W = 24
) (
   input  logic           clk,
   input  logic           arst,
   input  logic           start,
   input  logic [2*W-1:0] n,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   root
);

   localparam int unsigned RMW   = W + 2;
   localparam int unsigned CNT_W = $clog2(W + 1);

   logic [RMW-1:0]   rem_q;
   logic [RMW-1:0]   rem_src;
   logic [RMW-1:0]   acc;
   logic [RMW-1:0]   trial;
   logic [RMW-1:0]   rem_nx;
   logic [W-1:0]     root_src;
   logic [W-1:0]     root_nx;
   logic [2*W-1:0]   nsh_q;
   logic [1:0]       pair;
   logic [CNT_W-1:0] cnt_q;
   logic             ge;

   // One restoring step: bring down two radicand bits, try subtracting {root,01}.
   always_comb begin
      rem_src  = start ? '0 : rem_q;
      root_src = start ? '0 : root;
      pair     = start ? n[2*W-1 -: 2] : nsh_q[2*W-1 -: 2];
      acc      = (rem_src << 2) | RMW'(pair);
      trial    = {root_src, 2'b01};
      ge       = (acc >= trial);
      rem_nx   = ge ? (acc - trial) : acc;
      root_nx  = {root_src[W-2:0], ge};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rem_q <= '0;
         root  <= '0;
         nsh_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (start) begin
         rem_q <= rem_nx;
         root  <= root_nx;
         nsh_q <= n << 2;
         cnt_q <= CNT_W'(1);
         busy  <= 1'b1;
         done  <= 1'b0;
      end else if (busy) begin
         rem_q <= rem_nx;
         root  <= root_nx;
         nsh_q <= nsh_q << 2;
         cnt_q <= cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(W - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_sqrt_iter.sv
// Floating-point square root with valid/ready handshakes: exact serial root
// (truncated) or single-cycle bit-trick estimate, selected by APPROX.
module fp_sqrt_iter
   import fp_sqrt_pkg::*;
#(
   parameter int unsigned EXP_W  = 8,
   parameter int unsigned MAN_W  = 23,
   parameter int unsigned APPROX = 0
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic [EXP_W+MAN_W:0]     in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [EXP_W+MAN_W:0]     out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned DW = 1 + EXP_W + MAN_W;
   localparam int unsigned RW = MAN_W + 1;
   localparam int unsigned NW = 2 * RW;
   localparam int unsigned SW = EXP_W + 2;

   localparam logic [EXP_W-1:0] BIAS  = EXP_W'(bias(EXP_W));
   localparam logic [DW-1:0]    QNAN  = DW'(qnan(EXP_W, MAN_W));
   localparam logic [DW-1:0]    PINF  = DW'(pinf(EXP_W, MAN_W));
   localparam logic [DW-1:0]    BWORD = DW'({BIAS, {MAN_W{1'b0}}});

   state_t             state_q, state_d;
   op_class_t          cls;
   logic               op_sign;
   logic [EXP_W-1:0]   op_exp;
   logic [MAN_W-1:0]   op_frac;
   logic [DW-1:0]      special_res;
   logic [DW-1:0]      t_diff;
   logic [DW-1:0]      approx_res;
   logic signed [SW-1:0] e_unb;
   logic signed [SW-1:0] e_half;
   logic               odd;
   logic [EXP_W-1:0]   res_exp;
   logic [NW-1:0]      radicand;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [DW-1:0]      out_data_d;
   logic               start;
   logic               calc_busy;
   logic               calc_done;
   logic [RW-1:0]      root;
   logic               root_hidden_unused;
   logic [MAN_W-1:0]   root_frac;

   assign {op_sign, op_exp, op_frac} = in_data;
   assign {root_hidden_unused, root_frac} = root;

   // Operand classification, first match wins; denormals flush to signed zero.
   always_comb begin
      cls         = CLS_NORM;
      special_res = '0;
      if (op_exp == '0) begin
         cls         = CLS_ZERO;
         special_res = {op_sign, (DW-1)'(0)};
      end else if ((&op_exp) && (|op_frac)) begin
         cls         = CLS_NAN;
         special_res = QNAN;
      end else if (op_sign) begin
         cls         = CLS_NAN;
         special_res = QNAN;
      end else if (&op_exp) begin
         cls         = CLS_INF;
         special_res = PINF;
      end
   end

   // Halved exponent and radicand alignment; an odd exponent moves one bit into the root.
   always_comb begin
      e_unb    = $signed({2'b00, op_exp}) - $signed(SW'(BIAS));
      odd      = e_unb[0];
      e_half   = (e_unb - $signed(SW'(odd))) >>> 1;
      res_exp  = EXP_W'(e_half + $signed(SW'(BIAS)));
      radicand = odd ? (NW'({1'b1, op_frac}) << (MAN_W + 1))
                     : (NW'({1'b1, op_frac}) << MAN_W);
   end

   always_comb begin
      t_diff     = in_data - BWORD;
      approx_res = {t_diff[DW-1], t_diff[DW-1:1]} + BWORD;
   end

   isqrt_serial #(
      .W (RW)
   ) u_isqrt (
      .clk   (clk),
      .arst  (arst),
      .start (start),
      .n     (radicand),
      .busy  (calc_busy),
      .done  (calc_done),
      .root  (root)
   );

   always_comb begin
      state_d    = state_q;
      out_data_d = out_data;
      exp_d      = exp_q;
      start      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               if (cls != CLS_NORM) begin
                  out_data_d = special_res;
                  state_d    = DONE;
               end else if (APPROX != 0) begin
                  out_data_d = approx_res;
                  state_d    = DONE;
               end else begin
                  start   = 1'b1;
                  exp_d   = res_exp;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (calc_done && !calc_busy) begin
               out_data_d = {1'b0, exp_q, root_frac};
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         exp_q     <= '0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         out_data  <= out_data_d;
         exp_q     <= exp_d;
      end
   end

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Bench for fp_sqrt_iter: exact (index 0) and bit-trick (index 1) instances,
// directed cases with literal results, plus random operands against a reference model.
module tb_fp_sqrt_iter;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic [31:0] in_data   [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] out_data  [2];
   logic        out_valid [2];
   logic        out_ready [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .APPROX(0)) dut_exact (
      .clk       (clk),
      .arst      (arst),
      .in_data   (in_data[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .out_data  (out_data[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0])
   );

   fp_sqrt_iter #(.EXP_W(8), .MAN_W(23), .APPROX(1)) dut_approx (
      .clk       (clk),
      .arst      (arst),
      .in_data   (in_data[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .out_data  (out_data[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic bit is_special(input logic [31:0] x);
      return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) || x[31];
   endfunction

   // Reference: classification, then either floor(sqrt) on the scaled significand
   // or the bias-subtract / halve (floor) / bias-add estimate.
   function automatic logic [31:0] ref_sqrt(input bit apx, input logic [31:0] x);
      logic [7:0]  ex;
      logic [31:0] t;
      int          ti, e, odd;
      longint      n, r;
      ex = x[30:23];
      if (ex == 8'h00) return {x[31], 31'd0};
      if (ex == 8'hFF && x[22:0] != 23'd0) return 32'h7FC00000;
      if (x[31]) return 32'h7FC00000;
      if (ex == 8'hFF) return 32'h7F800000;
      if (apx) begin
         t  = x - 32'h3F800000;
         ti = $signed(t);
         ti = (ti - (ti & 1)) / 2;
         return 32'(ti) + 32'h3F800000;
      end
      e   = int'(ex) - 127;
      odd = e & 1;
      n   = longint'({1'b1, x[22:0]}) << (23 + odd);
      r   = longint'($sqrt(real'(n)));
      while (r * r > n) r--;
      while ((r + 1) * (r + 1) <= n) r++;
      return {1'b0, 8'((e - odd) / 2 + 127), r[22:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int d, input logic [31:0] x);
      int guard = 0;
      while (in_ready[d] !== 1'b1 && guard < 100) begin
         step();
         guard++;
      end
      if (guard >= 100) check("ready_timeout", 32'(in_ready[d]), 32'd1);
      in_data[d]  = x;
      in_valid[d] = 1'b1;
      step();
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_result(input int d, output int lat, output logic [31:0] res);
      lat = 1;
      while (out_valid[d] !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      if (lat >= 100) check("valid_timeout", 32'(out_valid[d]), 32'd1);
      res = out_data[d];
   endtask

   task automatic release_out(input int d);
      out_ready[d] = 1'b1;
      step();
      out_ready[d] = 1'b0;
   endtask

   // One full transaction; expected taken from a literal when given, else from the model.
   task automatic run(input int d, input logic [31:0] x, input bit use_lit,
                      input logic [31:0] lit, input string tag);
      int          lat;
      logic [31:0] res;
      logic [31:0] want;
      int          want_lat;
      want     = use_lit ? lit : ref_sqrt(d == 1, x);
      want_lat = (d == 1 || is_special(x)) ? 1 : 25;
      start_op(d, x);
      wait_result(d, lat, res);
      check(tag, res, want);
      check({tag, "_lat"}, 32'(lat), 32'(want_lat));
      release_out(d);
      check({tag, "_idle"}, 32'(in_ready[d]), 32'd1);
   endtask

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
   } vec_t;

   initial begin
      vec_t        exact_tab [9];
      vec_t        apx_tab   [4];
      int          lat;
      logic [31:0] res;
      logic [31:0] x;

      for (int d = 0; d < 2; d++) begin
         in_data[d]   = '0;
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
      end
      exact_tab = '{'{32'h40800000, 32'h40000000}, '{32'h40000000, 32'h3FB504F3},
                    '{32'h3F800000, 32'h3F800000}, '{32'h3E800000, 32'h3F000000},
                    '{32'hBF800000, 32'h7FC00000}, '{32'h7F800001, 32'h7FC00000},
                    '{32'h7F800000, 32'h7F800000}, '{32'h80000000, 32'h80000000},
                    '{32'h00000001, 32'h00000000}};
      apx_tab   = '{'{32'h40800000, 32'h40000000}, '{32'hBF800000, 32'h7FC00000},
                    '{32'h80000000, 32'h80000000}, '{32'h7F800000, 32'h7F800000}};

      repeat (3) @(posedge clk);
      #1;
      arst = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", 32'(in_ready[d]), 32'd1);
         check("rst_out_valid", 32'(out_valid[d]), 32'd0);
         check("rst_out_data", out_data[d], 32'd0);
      end

      foreach (exact_tab[i]) run(0, exact_tab[i].x, 1'b1, exact_tab[i].y, "exact_dir");
      foreach (apx_tab[i])   run(1, apx_tab[i].x, 1'b1, apx_tab[i].y, "apx_dir");

      // Backpressure: result frozen, second operand held off until the transfer.
      start_op(0, 32'h40000000);
      wait_result(0, lat, res);
      check("bp_first", res, 32'h3FB504F3);
      in_data[0]  = 32'h41100000;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_data", out_data[0], 32'h3FB504F3);
         check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
         check("bp_hold_ready", 32'(in_ready[0]), 32'd0);
      end
      release_out(0);
      check("bp_idle_ready", 32'(in_ready[0]), 32'd1);
      check("bp_idle_valid", 32'(out_valid[0]), 32'd0);
      step();
      in_valid[0] = 1'b0;
      check("bp_second_busy", 32'(in_ready[0]), 32'd0);
      wait_result(0, lat, res);
      check("bp_second", res, 32'h40400000);
      check("bp_second_lat", 32'(lat), 32'd25);
      release_out(0);

      // Reset in the middle of the serial root.
      start_op(0, 32'h40800000);
      repeat (9) step();
      arst = 1'b1;
      #1;
      check("abort_valid", 32'(out_valid[0]), 32'd0);
      check("abort_ready", 32'(in_ready[0]), 32'd1);
      step();
      arst = 1'b0;
      step();
      run(0, 32'h41100000, 1'b1, 32'h40400000, "after_abort");

      // Random exact operands over the full encoding space.
      for (int i = 0; i < 300; i++) begin
         x = $urandom;
         if ($urandom_range(0, 3) != 0) x[31] = 1'b0;
         if ($urandom_range(0, 9) != 0) x[30:23] = 8'($urandom_range(1, 254));
         run(0, x, 1'b0, 32'd0, "exact_rnd");
      end

      // Random normals through the estimate path.
      for (int i = 0; i < 10000; i++) begin
         x         = $urandom;
         x[31]     = ($urandom_range(0, 19) == 0);
         x[30:23]  = 8'($urandom_range(1, 254));
         run(1, x, 1'b0, 32'd0, "apx_rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
